// File: rtl/seg7_pkg.sv
// Shared constants and BCD-to-segment table for the 7-segment display blocks.
// Segment patterns are active-high, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;
  localparam int NUM_DIGITS = 6;

  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // Illegal BCD codes show a dash so a bad upstream value is visible, never blank.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] r;
    r = SEG_DASH;
    case (v)
      4'd0: r = 7'h3F;
      4'd1: r = 7'h06;
      4'd2: r = 7'h5B;
      4'd3: r = 7'h4F;
      4'd4: r = 7'h66;
      4'd5: r = 7'h6D;
      4'd6: r = 7'h7D;
      4'd7: r = 7'h07;
      4'd8: r = 7'h7F;
      4'd9: r = 7'h6F;
      default: r = SEG_DASH;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit value to active-high 7-segment pattern.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] pattern
);
  assign pattern = bcd_to_seg(value);
endmodule

// File: rtl/seg7_scan_display.sv
// Six-digit multiplexed 7-segment scanner with per-frame digit snapshot,
// anti-ghost blanking gap, per-digit blink / decimal point and hour-tens zero blanking.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int SCAN_HZ    = 1_000,
  parameter int BLANK_CYC  = 16,
  parameter int BLINK_HZ   = 2,
  parameter int SEG_ACT_LO = 1,
  parameter int SEL_ACT_LO = 1
) (
  input  logic       clk_sys,
  input  logic       RST,
  input  logic [3:0] disp_dat_0,
  input  logic [3:0] disp_dat_1,
  input  logic [3:0] disp_dat_2,
  input  logic [3:0] disp_dat_3,
  input  logic [3:0] disp_dat_4,
  input  logic [3:0] disp_dat_5,
  input  logic [5:0] dp_mask,
  input  logic [5:0] blink_mask,
  input  logic       blank_lz,
  output logic [7:0] seg,
  output logic [5:0] sel,
  output logic       frame_tick
);
  localparam int DIV  = CLK_HZ / SCAN_HZ;
  localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [7:0]            SEG_INACT = (SEG_ACT_LO != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] SEL_INACT = (SEL_ACT_LO != 0) ? '1 : '0;
  localparam logic [NUM_DIGITS-1:0] SEL_ONE   = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  logic [PW-1:0] pre;
  logic [2:0]    idx;
  logic [HW-1:0] bcnt;
  logic          hidden;

  logic [NUM_DIGITS-1:0][3:0] dig_in, dig_q;
  logic [NUM_DIGITS-1:0][6:0] pat;
  logic [NUM_DIGITS-1:0]      dp_q, blk_q;
  logic                       lz_q;

  logic                  slot_end, frame_end;
  logic [7:0]            seg_nxt;
  logic [NUM_DIGITS-1:0] sel_nxt;

  assign dig_in    = {disp_dat_5, disp_dat_4, disp_dat_3, disp_dat_2, disp_dat_1, disp_dat_0};
  assign slot_end  = (pre == PW'(DIV - 1));
  assign frame_end = slot_end && (idx == 3'(NUM_DIGITS - 1));

  // Prescaler, digit index and frame snapshot.
  always_ff @(posedge clk_sys) begin
    if (RST) begin
      pre        <= '0;
      idx        <= '0;
      dig_q      <= '0;
      dp_q       <= '0;
      blk_q      <= '0;
      lz_q       <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      pre        <= slot_end ? '0 : pre + 1'b1;
      frame_tick <= frame_end;
      if (slot_end)
        idx <= frame_end ? 3'd0 : idx + 3'd1;
      if (frame_end) begin
        dig_q <= dig_in;
        dp_q  <= dp_mask;
        blk_q <= blink_mask;
        lz_q  <= blank_lz;
      end
    end
  end

  // Blink phase runs free of the scan; it is only sampled at slot start.
  always_ff @(posedge clk_sys) begin
    if (RST) begin
      bcnt   <= '0;
      hidden <= 1'b0;
    end else if (bcnt == HW'(HALF - 1)) begin
      bcnt   <= '0;
      hidden <= ~hidden;
    end else begin
      bcnt <= bcnt + 1'b1;
    end
  end

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dec
    seg7_decode u_dec (.value(dig_q[d]), .pattern(pat[d]));
  end

  always_comb begin
    seg_nxt = {dp_q[idx], pat[idx]};
    if ((hidden && blk_q[idx]) ||
        (idx == 3'(NUM_DIGITS - 1) && lz_q && dig_q[NUM_DIGITS-1] == 4'd0))
      seg_nxt = {1'b0, SEG_OFF};
    sel_nxt = (pre >= PW'(BLANK_CYC)) ? (SEL_ONE << idx) : '0;
  end

  // Segments load at slot start, so they settle during the dead gap before sel asserts.
  always_ff @(posedge clk_sys) begin
    if (RST) begin
      seg <= SEG_INACT;
      sel <= SEL_INACT;
    end else begin
      if (pre == '0)
        seg <= (SEG_ACT_LO != 0) ? ~seg_nxt : seg_nxt;
      sel <= (SEL_ACT_LO != 0) ? ~sel_nxt : sel_nxt;
    end
  end
endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: expected per-slot segment codes are queued
// as frames are set up and checked cycle-by-cycle as the scanner reaches each slot.
module tb_seg7_scan_display;
  logic            clk_sys = 1'b0;
  logic            RST = 1'b1;
  logic [5:0][3:0] dd;
  logic [5:0]      dp_mask, blink_mask;
  logic            blank_lz;
  logic [3:0]      disp_dat_0, disp_dat_1, disp_dat_2, disp_dat_3, disp_dat_4, disp_dat_5;
  logic [7:0]      seg;
  logic [5:0]      sel;
  logic            frame_tick;

  assign disp_dat_0 = dd[0];
  assign disp_dat_1 = dd[1];
  assign disp_dat_2 = dd[2];
  assign disp_dat_3 = dd[3];
  assign disp_dat_4 = dd[4];
  assign disp_dat_5 = dd[5];

  always #5 clk_sys = ~clk_sys;

  seg7_scan_display #(
    .CLK_HZ(1200), .SCAN_HZ(100), .BLANK_CYC(2), .BLINK_HZ(1),
    .SEG_ACT_LO(1), .SEL_ACT_LO(1)
  ) dut (
    .clk_sys(clk_sys), .RST(RST),
    .disp_dat_0(disp_dat_0), .disp_dat_1(disp_dat_1), .disp_dat_2(disp_dat_2),
    .disp_dat_3(disp_dat_3), .disp_dat_4(disp_dat_4), .disp_dat_5(disp_dat_5),
    .dp_mask(dp_mask), .blink_mask(blink_mask), .blank_lz(blank_lz),
    .seg(seg), .sel(sel), .frame_tick(frame_tick)
  );

  localparam logic [6:0] LUT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  int         total = 0;
  int         bad = 0;
  int         push_k = 0;
  int         slot_k = 0;
  logic [7:0] exp_q [$];

  // 12-cycle slots, 600-cycle blink half-period: phase flips every 50 slots.
  function automatic logic [7:0] exp_seg(input logic [3:0] v, input int i, input int k,
                                         input logic [5:0] dpm, input logic [5:0] blm,
                                         input logic lz);
    logic [7:0] s;
    logic       hid;
    s   = {dpm[i], LUT[v]};
    hid = ((k / 50) % 2) == 1;
    if ((blm[i] && hid) || (i == 5 && lz && v == 4'd0)) s = 8'h00;
    return ~s;
  endfunction

  task automatic push_frame(input logic [5:0][3:0] v, input logic [5:0] dpm,
                            input logic [5:0] blm, input logic lz);
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(exp_seg(v[i], i, push_k, dpm, blm, lz));
      push_k++;
    end
  endtask

  task automatic drain(input int n);
    logic [7:0] e;
    logic [5:0] one, exp_sel;
    logic       exp_ft;
    int         idx;
    for (int s = 0; s < n; s++) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL drain: scoreboard empty at slot %0d", slot_k);
        return;
      end
      e   = exp_q.pop_front();
      idx = slot_k % 6;
      one = 6'b1 << idx;
      for (int j = 1; j <= 12; j++) begin
        @(posedge clk_sys); #1;
        exp_sel = (j >= 3) ? ~one : 6'h3F;
        exp_ft  = (j == 12 && idx == 5);
        total++;
        if (seg !== e) begin
          bad++;
          $display("FAIL seg slot=%0d cyc=%0d: got %h want %h", slot_k, j, seg, e);
        end
        total++;
        if (sel !== exp_sel) begin
          bad++;
          $display("FAIL sel slot=%0d cyc=%0d: got %h want %h", slot_k, j, sel, exp_sel);
        end
        total++;
        if (frame_tick !== exp_ft) begin
          bad++;
          $display("FAIL frame_tick slot=%0d cyc=%0d: got %b want %b", slot_k, j, frame_tick, exp_ft);
        end
      end
      slot_k++;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    for (int c = 0; c < 3; c++) begin
      dd = {$urandom, $urandom};
      dp_mask = 6'($urandom); blink_mask = 6'($urandom); blank_lz = 1'($urandom);
      @(posedge clk_sys); #1;
      total++;
      if (sel !== 6'h3F || seg !== 8'hFF || frame_tick !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d: got sel=%h seg=%h ft=%b want 3f ff 0", c, sel, seg, frame_tick);
      end
    end
    for (int i = 0; i < 6; i++) dd[i] = 4'(i + 1);
    dp_mask = '0; blink_mask = '0; blank_lz = 1'b0;
    exp_q.delete(); push_k = 0; slot_k = 0;
    push_frame('0, '0, '0, 1'b0);
    push_frame(dd, dp_mask, blink_mask, blank_lz);
    RST = 1'b0;
    drain(1);
  endtask

  task automatic test_scan_order();
    drain(11);
    push_frame(dd, dp_mask, blink_mask, blank_lz);
  endtask

  task automatic test_tearing();
    drain(3);
    for (int i = 0; i < 6; i++) dd[i] = 4'd9;
    push_frame(dd, dp_mask, blink_mask, blank_lz);
    drain(3);
  endtask

  task automatic test_illegal_zero();
    dd[5] = 4'd0; dd[2] = 4'hC; blank_lz = 1'b1;
    push_frame(dd, dp_mask, blink_mask, blank_lz);
    drain(6);
    blank_lz = 1'b0;
    push_frame(dd, dp_mask, blink_mask, blank_lz);
    drain(6);
  endtask

  task automatic test_blink_dp();
    for (int i = 0; i < 6; i++) dd[i] = 4'(i + 1);
    blink_mask = 6'b000011; dp_mask = 6'b000100; blank_lz = 1'b0;
    for (int f = 0; f < 12; f++) push_frame(dd, dp_mask, blink_mask, blank_lz);
    drain(6);
    drain(72);
  endtask

  task automatic test_reset_mid_slot();
    logic [7:0] e;
    logic [5:0] exp_sel;
    push_frame(dd, dp_mask, blink_mask, blank_lz);
    drain(4);
    e = exp_q.pop_front();
    for (int j = 1; j <= 7; j++) begin
      @(posedge clk_sys); #1;
      exp_sel = (j >= 3) ? 6'h2F : 6'h3F;
      total++;
      if (seg !== e || sel !== exp_sel) begin
        bad++;
        $display("FAIL pre_reset slot4 cyc=%0d: got seg=%h sel=%h want %h %h", j, seg, sel, e, exp_sel);
      end
    end
    RST = 1'b1;
    @(posedge clk_sys); #1;
    total++;
    if (sel !== 6'h3F || seg !== 8'hFF || frame_tick !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: got sel=%h seg=%h ft=%b want 3f ff 0", sel, seg, frame_tick);
    end
    exp_q.delete(); push_k = 0; slot_k = 0;
    push_frame('0, '0, '0, 1'b0);
    RST = 1'b0;
    drain(6);
  endtask

  // Invariant watcher: never more than one active-low select.
  always @(negedge clk_sys) begin
    if (!$isunknown(sel) && $countones(~sel) > 1) begin
      bad++;
      total++;
      $display("FAIL sel_onehot: got %h want at most one zero bit", sel);
    end
  end

  initial begin
    dd = '0; dp_mask = '0; blink_mask = '0; blank_lz = 1'b0;
    test_reset();
    test_scan_order();
    test_tearing();
    test_illegal_zero();
    test_blink_dp();
    test_reset_mid_slot();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
